// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: datapath widths, boolean
// constants, FSM state encodings and the default cache geometry.
package inst_fetcher_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;

    // Default direct-mapped cache geometry (entries and log2 of entries).
    localparam int DEFAULT_ICACHE_SIZE  = 256;
    localparam int DEFAULT_ICACHE_IDX_W = 8;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_MEM_WAIT = 2'd1,
        FETCH_HOLD     = 2'd2,
        FETCH_DRAIN    = 2'd3
    } fetch_state_e;

    // One delivered instruction as seen by the decoder.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] inst;
        logic                         predict;
    } fetch_pkt_t;

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill,
// valid bits cleared asynchronously on reset. Addresses are word addresses
// (pc[31:2]); index is the low IDX_W bits, tag is the rest.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int SIZE  = DEFAULT_ICACHE_SIZE,
    parameter int IDX_W = DEFAULT_ICACHE_IDX_W
) (
    input  logic                         in_clk,
    input  logic                         in_rst_n,
    input  logic [ADDRESS_WIDTH-3:0]     in_rd_word,
    output logic                         out_hit,
    output logic [INSTRUCTION_WIDTH-1:0] out_rd_data,
    input  logic                         in_fill_en,
    input  logic [ADDRESS_WIDTH-3:0]     in_fill_word,
    input  logic [INSTRUCTION_WIDTH-1:0] in_fill_data
);

    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

    logic [SIZE-1:0]              valid_q;
    logic [TAG_W-1:0]             tag_mem  [SIZE];
    logic [INSTRUCTION_WIDTH-1:0] data_mem [SIZE];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] fill_tag;

    assign rd_idx   = in_rd_word[IDX_W-1:0];
    assign rd_tag   = in_rd_word[ADDRESS_WIDTH-3:IDX_W];
    assign fill_idx = in_fill_word[IDX_W-1:0];
    assign fill_tag = in_fill_word[ADDRESS_WIDTH-3:IDX_W];

    assign out_hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign out_rd_data = data_mem[rd_idx];

    // Valid bits: cleared by reset, set by a fill (fills always overwrite).
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q <= '0;
        end else if (in_fill_en) begin
            valid_q[fill_idx] <= TRUE;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge in_clk) begin
        if (in_fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= in_fill_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher between the PC unit and the decoder. Takes one fetch
// at a time, returns the instruction with its prediction bit, and services
// misses over the word-wide memory port.
// Build option: define ICACHE_EN to back the fetcher with a direct-mapped
// cache; without it every fetch goes to memory.
//
// Handshakes: a fetch is accepted on an edge where in_pc_enable=1,
// out_pc_stall=0, in_flush_enable=0 and in_rdy=1. Delivery is a one-cycle
// pulse on out_dec_enable/out_pc_last_enable with data valid in that cycle;
// out_pc_stall covers the pulse cycle so pulses are always separated.
// out_mem_req is a level held with a stable address until in_mem_done.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_SIZE  = DEFAULT_ICACHE_SIZE,
    parameter int ICACHE_IDX_W = DEFAULT_ICACHE_IDX_W
) (
    input  logic                         in_clk,
    input  logic                         in_rst_n,
    input  logic                         in_rdy,
    input  logic                         in_flush_enable,
    input  logic                         in_pc_enable,
    input  logic [ADDRESS_WIDTH-1:0]     in_pc,
    input  logic                         in_pc_predict,
    output logic                         out_pc_stall,
    output logic                         out_pc_last_enable,
    output logic [ADDRESS_WIDTH-1:0]     out_pc_last_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_pc_last_inst,
    output logic                         out_mem_req,
    output logic [ADDRESS_WIDTH-1:0]     out_mem_addr,
    input  logic                         in_mem_done,
    input  logic [INSTRUCTION_WIDTH-1:0] in_mem_inst,
    input  logic                         in_dec_stall,
    output logic                         out_dec_enable,
    output logic [ADDRESS_WIDTH-1:0]     out_dec_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_dec_inst,
    output logic                         out_dec_predict,
    output fetch_state_e                 out_dbg_state
);

    // Cache geometry must be a power of two with at least two entries.
    if ((ICACHE_SIZE < 2) || (ICACHE_SIZE != (1 << ICACHE_IDX_W))) begin : g_bad_cfg
        $error("inst_fetcher: ICACHE_SIZE must equal 2**ICACHE_IDX_W and be >= 2");
    end

    fetch_state_e                 state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
    logic                         predict_q, predict_d;
    logic [INSTRUCTION_WIDTH-1:0] inst_q, inst_d;
    logic                         pulse_q, pulse_d;
    fetch_pkt_t                   dec_q, dec_d;
    logic                         mem_req_q, mem_req_d;
    logic [ADDRESS_WIDTH-1:0]     mem_addr_q, mem_addr_d;

    logic                         cache_hit;
    logic [INSTRUCTION_WIDTH-1:0] cache_data;

`ifdef ICACHE_EN
    logic cache_fill;

    // Every memory response is written into the cache, including drained ones.
    assign cache_fill = in_rdy && in_mem_done &&
                        ((state_q == FETCH_MEM_WAIT) || (state_q == FETCH_DRAIN));

    inst_fetcher_icache #(
        .SIZE  (ICACHE_SIZE),
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_rd_word   (in_pc[ADDRESS_WIDTH-1:2]),
        .out_hit      (cache_hit),
        .out_rd_data  (cache_data),
        .in_fill_en   (cache_fill),
        .in_fill_word (pc_q[ADDRESS_WIDTH-1:2]),
        .in_fill_data (in_mem_inst)
    );
`else
    assign cache_hit  = FALSE;
    assign cache_data = '0;
`endif

    // Next-state and next-output logic; a flush overrides every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        predict_d  = predict_q;
        inst_d     = inst_q;
        pulse_d    = FALSE;
        dec_d      = dec_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            FETCH_IDLE: begin
                // No acceptance during a pulse cycle keeps pulses separated.
                if (!in_flush_enable && in_pc_enable && !pulse_q) begin
                    pc_d      = in_pc;
                    predict_d = in_pc_predict;
                    if (cache_hit) begin
                        inst_d = cache_data;
                        if (in_dec_stall) begin
                            state_d = FETCH_HOLD;
                        end else begin
                            pulse_d = TRUE;
                            dec_d   = '{pc: in_pc, inst: cache_data, predict: in_pc_predict};
                        end
                    end else begin
                        mem_req_d  = TRUE;
                        mem_addr_d = in_pc;
                        state_d    = FETCH_MEM_WAIT;
                    end
                end
            end

            FETCH_MEM_WAIT: begin
                if (in_mem_done) begin
                    mem_req_d = FALSE;
                    inst_d    = in_mem_inst;
                    if (in_flush_enable) begin
                        state_d = FETCH_IDLE;
                    end else if (in_dec_stall) begin
                        state_d = FETCH_HOLD;
                    end else begin
                        pulse_d = TRUE;
                        dec_d   = '{pc: pc_q, inst: in_mem_inst, predict: predict_q};
                        state_d = FETCH_IDLE;
                    end
                end else if (in_flush_enable) begin
                    // The request cannot be withdrawn; wait it out without delivering.
                    state_d = FETCH_DRAIN;
                end
            end

            FETCH_HOLD: begin
                if (in_flush_enable) begin
                    state_d = FETCH_IDLE;
                end else if (!in_dec_stall) begin
                    pulse_d = TRUE;
                    dec_d   = '{pc: pc_q, inst: inst_q, predict: predict_q};
                    state_d = FETCH_IDLE;
                end
            end

            FETCH_DRAIN: begin
                if (in_mem_done) begin
                    mem_req_d = FALSE;
                    state_d   = FETCH_IDLE;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State and datapath registers; in_rdy low freezes everything.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= ZERO_ADDR;
            predict_q  <= FALSE;
            inst_q     <= '0;
            pulse_q    <= FALSE;
            dec_q      <= '0;
            mem_req_q  <= FALSE;
            mem_addr_q <= ZERO_ADDR;
        end else if (in_rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            predict_q  <= predict_d;
            inst_q     <= inst_d;
            pulse_q    <= pulse_d;
            dec_q      <= dec_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign out_pc_stall       = (state_q != FETCH_IDLE) || pulse_q;
    assign out_dec_enable     = pulse_q && in_rdy;
    assign out_pc_last_enable = pulse_q && in_rdy;
    assign out_dec_pc         = dec_q.pc;
    assign out_dec_inst       = dec_q.inst;
    assign out_dec_predict    = dec_q.predict;
    assign out_pc_last_pc     = dec_q.pc;
    assign out_pc_last_inst   = dec_q.inst;
    assign out_mem_req        = mem_req_q;
    assign out_mem_addr       = mem_addr_q;
    assign out_dbg_state      = state_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher. Works with or without ICACHE_EN:
// refetches are expected to hit only when the cache is built in.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

`ifdef ICACHE_EN
    localparam bit HAS_CACHE = 1'b1;
`else
    localparam bit HAS_CACHE = 1'b0;
`endif

    logic         in_clk;
    logic         in_rst_n;
    logic         in_rdy;
    logic         in_flush_enable;
    logic         in_pc_enable;
    logic [31:0]  in_pc;
    logic         in_pc_predict;
    logic         out_pc_stall;
    logic         out_pc_last_enable;
    logic [31:0]  out_pc_last_pc;
    logic [31:0]  out_pc_last_inst;
    logic         out_mem_req;
    logic [31:0]  out_mem_addr;
    logic         in_mem_done;
    logic [31:0]  in_mem_inst;
    logic         in_dec_stall;
    logic         out_dec_enable;
    logic [31:0]  out_dec_pc;
    logic [31:0]  out_dec_inst;
    logic         out_dec_predict;
    fetch_state_e out_dbg_state;

    int errors = 0;
    int checks = 0;

    // Expected deliveries: {pc, inst, predict}.
    logic [64:0] exp_q[$];

    inst_fetcher dut (
        .in_clk             (in_clk),
        .in_rst_n           (in_rst_n),
        .in_rdy             (in_rdy),
        .in_flush_enable    (in_flush_enable),
        .in_pc_enable       (in_pc_enable),
        .in_pc              (in_pc),
        .in_pc_predict      (in_pc_predict),
        .out_pc_stall       (out_pc_stall),
        .out_pc_last_enable (out_pc_last_enable),
        .out_pc_last_pc     (out_pc_last_pc),
        .out_pc_last_inst   (out_pc_last_inst),
        .out_mem_req        (out_mem_req),
        .out_mem_addr       (out_mem_addr),
        .in_mem_done        (in_mem_done),
        .in_mem_inst        (in_mem_inst),
        .in_dec_stall       (in_dec_stall),
        .out_dec_enable     (out_dec_enable),
        .out_dec_pc         (out_dec_pc),
        .out_dec_inst       (out_dec_inst),
        .out_dec_predict    (out_dec_predict),
        .out_dbg_state      (out_dbg_state)
    );

    // Clock
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents model; pc 0 holds the canonical nop 0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 | (a << 8);
    endfunction

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic start_cycle();
        @(posedge in_clk);
        #1;
    endtask

    // Wait until the fetcher is free, present one fetch for a single cycle.
    task automatic issue(input logic [31:0] pc, input logic pred, input bit push);
        int n;
        n = 0;
        start_cycle();
        while (out_pc_stall !== 1'b0 && n < 20) begin
            start_cycle();
            n++;
        end
        chk("issue_idle", 32'(out_pc_stall), 32'd0);
        in_pc_enable  = 1'b1;
        in_pc         = pc;
        in_pc_predict = pred;
        if (push) exp_q.push_back({pc, mem_word(pc), pred});
        start_cycle();
        in_pc_enable  = 1'b0;
    endtask

    // Full fetch: hit delivers one cycle after acceptance; a miss keeps the
    // request up for lat cycles (done in the last one) and delivers after.
    task automatic do_fetch(input logic [31:0] pc, input logic pred, input bit exp_hit, input int lat);
        issue(pc, pred, 1'b1);
        if (!exp_hit) begin
            for (int i = 0; i < lat; i++) begin
                if (i == lat - 1) begin
                    in_mem_done = 1'b1;
                    in_mem_inst = mem_word(pc);
                end
                @(negedge in_clk);
                chk("miss_req", 32'(out_mem_req), 32'd1);
                chk("miss_addr", out_mem_addr, pc);
                chk("miss_no_pulse", 32'(out_dec_enable), 32'd0);
                start_cycle();
            end
            in_mem_done = 1'b0;
            in_mem_inst = '0;
        end
        @(negedge in_clk);
        chk("deliver_pulse", 32'(out_dec_enable), 32'd1);
        chk("deliver_req_low", 32'(out_mem_req), 32'd0);
        chk("deliver_stall", 32'(out_pc_stall), 32'd1);
        start_cycle();
        @(negedge in_clk);
        chk("single_pulse", 32'(out_dec_enable), 32'd0);
    endtask

    // Scoreboard: every delivery pulse must match the oldest expected fetch.
    always @(negedge in_clk) begin
        if (in_rst_n === 1'b1 && out_dec_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 32'(out_dec_enable), 32'd0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("dec_pc", out_dec_pc, e[64:33]);
                chk("dec_inst", out_dec_inst, e[32:1]);
                chk("dec_predict", 32'(out_dec_predict), 32'(e[0]));
                chk("last_enable", 32'(out_pc_last_enable), 32'd1);
                chk("last_pc", out_pc_last_pc, e[64:33]);
                chk("last_inst", out_pc_last_inst, e[32:1]);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        in_rst_n        = 1'b0;
        in_rdy          = 1'b1;
        in_flush_enable = 1'b0;
        in_pc_enable    = 1'b0;
        in_pc           = '0;
        in_pc_predict   = 1'b0;
        in_mem_done     = 1'b0;
        in_mem_inst     = '0;
        in_dec_stall    = 1'b0;
        repeat (3) start_cycle();
        in_rst_n = 1'b1;

        // Reset state
        @(negedge in_clk);
        chk("rst_stall", 32'(out_pc_stall), 32'd0);
        chk("rst_req", 32'(out_mem_req), 32'd0);
        chk("rst_addr", out_mem_addr, 32'd0);
        chk("rst_dec_en", 32'(out_dec_enable), 32'd0);
        chk("rst_last_en", 32'(out_pc_last_enable), 32'd0);
        chk("rst_dec_pc", out_dec_pc, 32'd0);
        chk("rst_dec_inst", out_dec_inst, 32'd0);
        chk("rst_state", 32'(out_dbg_state), 32'(FETCH_IDLE));

        // Cold miss, then refetch of the same pc
        do_fetch(32'h0000_0000, 1'b1, 1'b0, 3);
        do_fetch(32'h0000_0000, 1'b0, HAS_CACHE, 2);

        // Conflicting index: 0x400 evicts 0x0, so both miss
        do_fetch(32'h0000_0400, 1'b1, 1'b0, 2);
        do_fetch(32'h0000_0000, 1'b1, 1'b0, 1);

        // Decoder stall across a 2-cycle miss on 0x8
        in_dec_stall = 1'b1;
        issue(32'h0000_0008, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                in_mem_done = 1'b1;
                in_mem_inst = mem_word(32'h8);
            end
            @(negedge in_clk);
            chk("stall_no_pulse", 32'(out_dec_enable), 32'd0);
            chk("stall_busy", 32'(out_pc_stall), 32'd1);
            if (i == 2) chk("stall_hold_state", 32'(out_dbg_state), 32'(FETCH_HOLD));
            start_cycle();
            in_mem_done = 1'b0;
        end
        in_dec_stall = 1'b0;
        @(negedge in_clk);
        chk("release_no_pulse_yet", 32'(out_dec_enable), 32'd0);
        chk("release_busy", 32'(out_pc_stall), 32'd1);
        start_cycle();
        @(negedge in_clk);
        chk("release_pulse", 32'(out_dec_enable), 32'd1);
        start_cycle();
        @(negedge in_clk);
        chk("release_single", 32'(out_dec_enable), 32'd0);

        // Flush in the first MEM_WAIT cycle of a miss on 0xC
        issue(32'h0000_000C, 1'b0, 1'b0);
        in_flush_enable = 1'b1;
        @(negedge in_clk);
        chk("flush_req", 32'(out_mem_req), 32'd1);
        start_cycle();
        in_flush_enable = 1'b0;
        @(negedge in_clk);
        chk("drain_state", 32'(out_dbg_state), 32'(FETCH_DRAIN));
        chk("drain_req", 32'(out_mem_req), 32'd1);
        chk("drain_addr", out_mem_addr, 32'h0000_000C);
        start_cycle();
        in_mem_done = 1'b1;
        in_mem_inst = mem_word(32'hC);
        @(negedge in_clk);
        chk("drain_req_done", 32'(out_mem_req), 32'd1);
        start_cycle();
        in_mem_done = 1'b0;
        @(negedge in_clk);
        chk("drain_no_pulse", 32'(out_dec_enable), 32'd0);
        chk("drain_req_low", 32'(out_mem_req), 32'd0);
        chk("drain_idle", 32'(out_pc_stall), 32'd0);
        do_fetch(32'h0000_000C, 1'b1, HAS_CACHE, 2);

        // Global ready low during a miss on 0x20 freezes the request
        issue(32'h0000_0020, 1'b1, 1'b1);
        @(negedge in_clk);
        chk("rdy_req", 32'(out_mem_req), 32'd1);
        start_cycle();
        in_rdy = 1'b0;
        @(negedge in_clk);
        chk("rdy_hold_req", 32'(out_mem_req), 32'd1);
        chk("rdy_hold_state", 32'(out_dbg_state), 32'(FETCH_MEM_WAIT));
        start_cycle();
        @(negedge in_clk);
        chk("rdy_hold_addr", out_mem_addr, 32'h0000_0020);
        start_cycle();
        in_rdy      = 1'b1;
        in_mem_done = 1'b1;
        in_mem_inst = mem_word(32'h20);
        @(negedge in_clk);
        chk("rdy_resume_req", 32'(out_mem_req), 32'd1);
        start_cycle();
        in_mem_done = 1'b0;
        @(negedge in_clk);
        chk("rdy_pulse", 32'(out_dec_enable), 32'd1);
        start_cycle();

        // Asynchronous reset in the middle of a miss on 0x10
        issue(32'h0000_0010, 1'b1, 1'b0);
        @(negedge in_clk);
        chk("rst_mid_req", 32'(out_mem_req), 32'd1);
        start_cycle();
        in_rst_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(out_mem_req), 32'd0);
        chk("rst_async_addr", out_mem_addr, 32'd0);
        chk("rst_async_stall", 32'(out_pc_stall), 32'd0);
        chk("rst_async_dec_pc", out_dec_pc, 32'd0);
        chk("rst_async_last_inst", out_pc_last_inst, 32'd0);
        chk("rst_async_state", 32'(out_dbg_state), 32'(FETCH_IDLE));
        start_cycle();
        in_rst_n = 1'b1;
        start_cycle();
        in_mem_done = 1'b1;
        in_mem_inst = 32'hDEAD_BEEF;
        @(negedge in_clk);
        chk("late_done_no_pulse", 32'(out_dec_enable), 32'd0);
        start_cycle();
        in_mem_done = 1'b0;
        @(negedge in_clk);
        chk("late_done_ignored", 32'(out_dec_enable), 32'd0);
        chk("late_done_req", 32'(out_mem_req), 32'd0);
        chk("late_done_state", 32'(out_dbg_state), 32'(FETCH_IDLE));
        do_fetch(32'h0000_0010, 1'b0, 1'b0, 2);

        start_cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
